// File: rtl/lcm_pkg.sv
// Shared types and sizes for the LCM engine.
// Timeout support is enabled with LCM_GCD_TIMEOUT_EN.
package lcm_pkg;

    localparam int OP_W        = 8;
    localparam int RES_W       = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        GREQ,
        GWAIT,
        GREL,
        MUL,
        DIV,
        FIN
    } lcm_state_t;

endpackage

// File: rtl/lcm_unit_seq_divider.sv
// 16/8 restoring divider, one quotient bit per cycle.
// The load cycle performs the first iteration; done pulses after 16.
module seq_divider
    import lcm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [RES_W-1:0] dividend,
    input  logic [OP_W-1:0]  divisor,
    output logic [RES_W-1:0] quotient,
    output logic             done
);

    logic [OP_W:0]    rem;
    logic [RES_W-1:0] quo;
    logic [OP_W-1:0]  dvs;
    logic [3:0]       cnt;
    logic             active;

    logic [OP_W:0]    src_r;
    logic [RES_W-1:0] src_q;
    logic [OP_W-1:0]  src_d;
    logic [OP_W:0]    sh;
    logic [OP_W:0]    rem_n;
    logic [RES_W-1:0] quo_n;
    logic             unused_rem_msb;

    // Remainder stays below the divisor, so its top bit never matters.
    assign unused_rem_msb = src_r[OP_W];

    always_comb begin
        src_r = load ? '0 : rem;
        src_q = load ? dividend : quo;
        src_d = load ? divisor : dvs;
        sh    = {src_r[OP_W-1:0], src_q[RES_W-1]};
        rem_n = sh;
        quo_n = {src_q[RES_W-2:0], 1'b0};
        if (sh >= {1'b0, src_d}) begin
            rem_n = sh - {1'b0, src_d};
            quo_n = {src_q[RES_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                rem    <= rem_n;
                quo    <= quo_n;
                dvs    <= divisor;
                cnt    <= 4'd1;
                active <= 1'b1;
            end else if (active) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo;

endmodule

// File: rtl/lcm_unit.sv
// LCM engine: drives the GCD stage, then shift-add multiply and divide.
// Define LCM_GCD_TIMEOUT_EN to bound the wait on the GCD stage.
module lcm_unit
    import lcm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             gcd_start,
    input  logic             gcd_done,
    input  logic [RES_W-1:0] gcd_result,
    output logic [RES_W-1:0] lcm,
    output logic             done,
    output logic             busy,
    output logic             err
);

    lcm_state_t       state;
    logic [OP_W-1:0]  a_r;
    logic [OP_W-1:0]  b_r;
    logic [OP_W-1:0]  g;
    logic [RES_W-1:0] ma;
    logic [OP_W-1:0]  mb;
    logic [RES_W-1:0] p;
    logic [2:0]       mcnt;
    logic             err_q;

    logic [RES_W-1:0] p_next;
    logic             div_load;
    logic             div_done;
    logic [RES_W-1:0] quotient;
    logic             t_hit;
    logic             unused_gcd_hi;

    assign unused_gcd_hi = ^gcd_result[RES_W-1:OP_W];

`ifdef LCM_GCD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state == GREQ || state == GWAIT) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end

    assign t_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign t_hit = 1'b0;
`endif

    assign p_next   = p + (mb[0] ? ma : '0);
    assign div_load = (state == MUL) && (mcnt == 3'd7);
    assign busy     = (state != IDLE);
    assign err      = err_q;

    seq_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .dividend (p_next),
        .divisor  (g),
        .quotient (quotient),
        .done     (div_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            g         <= '0;
            ma        <= '0;
            mb        <= '0;
            p         <= '0;
            mcnt      <= '0;
            lcm       <= '0;
            done      <= 1'b0;
            err_q     <= 1'b0;
            gcd_start <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    a_r <= a;
                    b_r <= b;
                    // Zero operands never touch the GCD stage.
                    if (a == '0 || b == '0) begin
                        lcm   <= '0;
                        err_q <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        gcd_start <= 1'b1;
                        state     <= GREQ;
                    end
                end
                GREQ: if (t_hit) begin
                    gcd_start <= 1'b0;
                    lcm       <= '0;
                    err_q     <= 1'b1;
                    done      <= 1'b1;
                    state     <= FIN;
                end else if (!gcd_done) begin
                    state <= GWAIT;
                end
                GWAIT: if (gcd_done) begin
                    g         <= gcd_result[OP_W-1:0];
                    gcd_start <= 1'b0;
                    state     <= GREL;
                end else if (t_hit) begin
                    gcd_start <= 1'b0;
                    lcm       <= '0;
                    err_q     <= 1'b1;
                    done      <= 1'b1;
                    state     <= FIN;
                end
                GREL: begin
                    ma    <= {{(RES_W-OP_W){1'b0}}, a_r};
                    mb    <= b_r;
                    p     <= '0;
                    mcnt  <= '0;
                    state <= MUL;
                end
                MUL: begin
                    p    <= p_next;
                    ma   <= {ma[RES_W-2:0], 1'b0};
                    mb   <= {1'b0, mb[OP_W-1:1]};
                    mcnt <= mcnt + 3'd1;
                    if (mcnt == 3'd7) state <= DIV;
                end
                DIV: if (div_done) begin
                    lcm   <= quotient;
                    err_q <= 1'b0;
                    done  <= 1'b1;
                    state <= FIN;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_unit.sv
// Bench for lcm_unit with a behavioural GCD stage and a stuck-done stub.
// Timeout checks are built when LCM_GCD_TIMEOUT_EN is defined.
module tb_lcm_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        gcd_start;
    logic        gcd_done;
    logic [15:0] gcd_result;
    logic [15:0] lcm;
    logic        done;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lcm_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .gcd_start  (gcd_start),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .lcm        (lcm),
        .done       (done),
        .busy       (busy),
        .err        (err)
    );

    function automatic int gcd_ref(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int lcm_ref(input int x, input int y);
        if (x == 0 || y == 0) return 0;
        return (x * y) / gcd_ref(x, y);
    endfunction

    // Behavioural GCD stage: random latency, result upper byte is junk.
    bit stub = 1'b0;
    int op_a = 1;
    int op_b = 1;
    int gcnt;
    bit gbusy;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            gcd_done   <= 1'b0;
            gcd_result <= '0;
            gbusy      <= 1'b0;
            gcnt       <= 0;
        end else if (stub) begin
            gcd_done <= 1'b1;
        end else if (gbusy) begin
            if (gcnt == 0) begin
                gcd_done   <= 1'b1;
                gcd_result <= {8'hA5, 8'(gcd_ref(op_a, op_b))};
                gbusy      <= 1'b0;
            end else begin
                gcnt <= gcnt - 1;
            end
        end else if (gcd_start && !gcd_done) begin
            gbusy <= 1'b1;
            gcnt  <= int'($urandom_range(0, 4));
        end else if (gcd_done && !gcd_start) begin
            gcd_done <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Cycle 1 is the cycle right after the accepting edge.
    task automatic wait_done(input bit hold, input bit pulse,
                             output int cyc, output int gcy);
        cyc = 0;
        gcy = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (!hold) start = pulse && (i == 3 || i == 20);
            if (pulse) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            if (gcd_start) gcy++;
            if (done) begin
                cyc = i;
                return;
            end
        end
        n_vec++;
        n_bad++;
        $display("FAIL wait_done: no done within 400 cycles");
    endtask

    task automatic run_op(input int x, input int y, input int exp,
                          input bit pulse);
        int cyc;
        int gcy;
        @(negedge clk);
        a = 8'(x);
        b = 8'(y);
        op_a = x;
        op_b = y;
        start = 1'b1;
        wait_done(1'b0, pulse, cyc, gcy);
        chk($sformatf("lcm(%0d,%0d)", x, y), lcm, exp);
        chk("err", err, 0);
        if (x == 0 || y == 0) begin
            chk("bypass_latency", cyc, 1);
            chk("bypass_gcd_start", gcy, 0);
        end else begin
            chk("latency", cyc, gcy + 26);
        end
        chk("busy_in_fin", busy, 1);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after_fin", busy, 0);
    endtask

    typedef struct {
        int x;
        int y;
        int l;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cyc;
        int gcy;
        int x;
        int y;
        bit seen;

        tbl = '{
            '{12, 18, 36},   '{0, 25, 0},     '{255, 254, 64770},
            '{200, 200, 200}, '{1, 1, 1},     '{25, 0, 0},
            '{4, 6, 12},     '{255, 255, 255}, '{1, 255, 255},
            '{128, 3, 384},  '{17, 19, 323},  '{0, 0, 0}
        };

        repeat (3) @(negedge clk);
        chk("rst_lcm", lcm, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_gcd_start", gcd_start, 0);
        reset = 1'b0;

        foreach (tbl[i]) run_op(tbl[i].x, tbl[i].y, tbl[i].l, 1'b0);

        for (int i = 0; i < 20; i++) begin
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(1, 255));
            run_op(x, y, lcm_ref(x, y), 1'b0);
        end

        // Start pulses while busy must not disturb the running operation.
        run_op(9, 6, 18, 1'b1);

        // Reset in the middle of DIV aborts at once.
        run_op(255, 254, 64770, 1'b0);
        @(negedge clk);
        a = 8'd9;
        b = 8'd12;
        op_a = 9;
        op_b = 12;
        start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (gcd_start) seen = 1'b1;
            if (seen && !gcd_start) break;
        end
        chk("gcd_handshake_seen", seen, 1);
        repeat (12) @(negedge clk);
        chk("busy_in_div", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_lcm", lcm, 0);
        chk("abort_gcd_start", gcd_start, 0);
        @(negedge clk);
        reset = 1'b0;
        run_op(4, 6, 12, 1'b0);

        // Start held high across completion retriggers from IDLE.
        @(negedge clk);
        a = 8'd3;
        b = 8'd5;
        op_a = 3;
        op_b = 5;
        start = 1'b1;
        wait_done(1'b1, 1'b0, cyc, gcy);
        chk("hold_lcm1", lcm, 15);
        chk("hold_latency1", cyc, gcy + 26);
        a = 8'd6;
        b = 8'd4;
        op_a = 6;
        op_b = 4;
        @(negedge clk);
        chk("hold_idle_gap", busy, 0);
        wait_done(1'b0, 1'b0, cyc, gcy);
        chk("hold_lcm2", lcm, 12);
        chk("hold_latency2", cyc, gcy + 26);
        @(negedge clk);
        chk("hold_end_idle", busy, 0);

`ifdef LCM_GCD_TIMEOUT_EN
        stub = 1'b1;
        repeat (2) @(negedge clk);
        a = 8'd5;
        b = 8'd7;
        start = 1'b1;
        wait_done(1'b0, 1'b0, cyc, gcy);
        chk("to_lcm", lcm, 0);
        chk("to_err", err, 1);
        chk("to_wait_cycles", gcy, 64);
        chk("to_latency", cyc, 65);
        stub = 1'b0;
        @(negedge clk);
        chk("to_done_pulse", done, 0);
        chk("to_gcd_start", gcd_start, 0);
        repeat (3) @(negedge clk);
        run_op(5, 7, 35, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
